sfp_norm_seq: RTL

- Normalization sequencer for the SFP path: accepts one vector of N unsigned lane values and sums it.
- It then drives the shared 20-bit iterative divider (start/busy/done/valid/a/b/val interface) once per lane, giving lane*2^FRAC/sum.
- It sits directly upstream of and around the divider: it feeds the operands, consumes the quotients and presents the normalized vector downstream.

---
 rtl/sfp_norm_seq.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/sfp_norm_seq.sv
// Normalization sequencer: sums a vector of N lanes, then drives the shared iterative
// divider once per lane to form lane*2^FRAC/sum. Define SFP_NORM_SIGNED_EN for two's-complement lanes.
module sfp_norm_seq #(
  parameter int unsigned N    = 8,
  parameter int unsigned DW   = 20,
  parameter int unsigned FRAC = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*DW-1:0]   in_data,
  output logic              div_start,
  output logic [DW-1:0]     div_a,
  output logic [DW-1:0]     div_b,
  input  logic              div_busy,
  input  logic              div_done,
  input  logic              div_valid,
  input  logic [DW-1:0]     div_val,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N*DW-1:0]   out_data,
  output logic              out_err
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned AW = DW + IW;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SUM   = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  logic [2:0]        state, state_d;
  logic [IW-1:0]     idx, idx_d;
  logic [AW-1:0]     acc, acc_d;
  logic [N*DW-1:0]   lanes, lanes_d;
  logic [N*DW-1:0]   out_data_d;
  logic              out_err_d, out_valid_d, div_start_d, in_ready_q, in_ready_d;
  logic [DW-1:0]     div_a_d, div_b_d;
  logic [DW-1:0]     cur_lane, cur_mag, div_b_c, q_store;
  logic [AW-1:0]     shifted;

`ifdef SFP_NORM_SIGNED_EN
  logic [N-1:0]      sgn, sgn_d;

  // Magnitude of a two's-complement lane; the most negative value saturates.
  function automatic logic [DW-1:0] lane_mag(input logic [DW-1:0] v);
    if (!v[DW-1]) return v;
    if (v == {1'b1, {(DW-1){1'b0}}}) return {1'b0, {(DW-1){1'b1}}};
    return ~v + DW'(1);
  endfunction
`else
  function automatic logic [DW-1:0] lane_mag(input logic [DW-1:0] v);
    return v;
  endfunction
`endif

  assign in_ready = in_ready_q & ~rst;
  assign cur_lane = lanes[idx*DW +: DW];
  assign cur_mag  = lane_mag(cur_lane);

  // Divisor: sum prescaled by 2^FRAC, clamped into [1, 2^DW-1].
  assign shifted = acc >> FRAC;
  always_comb begin
    div_b_c = shifted[DW-1:0];
    if (|shifted[AW-1:DW])
      div_b_c = {DW{1'b1}};
    else if (shifted[DW-1:0] == '0)
      div_b_c = DW'(1);
  end

  always_comb begin
    q_store = div_val;
`ifdef SFP_NORM_SIGNED_EN
    if (sgn[idx]) q_store = ~div_val + DW'(1);
`endif
    if (!div_valid) q_store = {DW{1'b1}};
  end

  always_comb begin
    state_d     = state;
    idx_d       = idx;
    acc_d       = acc;
    lanes_d     = lanes;
    out_data_d  = out_data;
    out_err_d   = out_err;
    out_valid_d = out_valid;
    div_start_d = 1'b0;
    div_a_d     = div_a;
    div_b_d     = div_b;
    in_ready_d  = 1'b0;
`ifdef SFP_NORM_SIGNED_EN
    sgn_d       = sgn;
`endif
    case (state)
      S_IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid) begin
          lanes_d    = in_data;
          acc_d      = '0;
          idx_d      = '0;
          out_data_d = '0;
          out_err_d  = 1'b0;
          in_ready_d = 1'b0;
          state_d    = S_SUM;
`ifdef SFP_NORM_SIGNED_EN
          for (int k = 0; k < int'(N); k++) sgn_d[k] = in_data[k*DW + DW - 1];
`endif
        end
      end
      S_SUM: begin
        acc_d = acc + AW'(cur_mag);
        if (idx == LAST) begin
          idx_d   = '0;
          state_d = S_ISSUE;
        end else begin
          idx_d = idx + 1'b1;
        end
      end
      S_ISSUE: begin
        if (idx == '0 && acc == '0) begin
          out_err_d   = 1'b1;
          out_data_d  = '0;
          out_valid_d = 1'b1;
          state_d     = S_OUT;
        end else if (!div_busy) begin
          div_a_d     = cur_mag;
          div_b_d     = div_b_c;
          div_start_d = 1'b1;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        // The done seen alongside our own start pulse belongs to an earlier operation.
        if (div_done && !div_start) begin
          out_data_d[idx*DW +: DW] = q_store;
          if (!div_valid) out_err_d = 1'b1;
          if (idx == LAST) begin
            out_valid_d = 1'b1;
            state_d     = S_OUT;
          end else begin
            idx_d   = idx + 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d    = S_IDLE;
        in_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      acc        <= '0;
      lanes      <= '0;
      out_data   <= '0;
      out_err    <= 1'b0;
      out_valid  <= 1'b0;
      div_start  <= 1'b0;
      div_a      <= '0;
      div_b      <= '0;
      in_ready_q <= 1'b1;
`ifdef SFP_NORM_SIGNED_EN
      sgn        <= '0;
`endif
    end else begin
      state      <= state_d;
      idx        <= idx_d;
      acc        <= acc_d;
      lanes      <= lanes_d;
      out_data   <= out_data_d;
      out_err    <= out_err_d;
      out_valid  <= out_valid_d;
      div_start  <= div_start_d;
      div_a      <= div_a_d;
      div_b      <= div_b_d;
      in_ready_q <= in_ready_d;
`ifdef SFP_NORM_SIGNED_EN
      sgn        <= sgn_d;
`endif
    end
  end

endmodule
